// File: rtl/exu_pkg.sv
// Shared definitions for the execute/memory stage: opcode encoding,
// default datapath geometry and the 4-bit immediate sign-extension helper.
package exu_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DEPTH  = 256;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_ADDI = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDI = 4'h4,
    OP_LD   = 4'h5,
    OP_ST   = 4'h6,
    OP_CMP  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JE   = 4'h9,
    OP_JNE  = 4'hA,
    OP_JA   = 4'hB,
    OP_JB   = 4'hC
  } opcode_e;

  // Replicate the immediate's sign bit across the full datapath word.
  function automatic logic [DEF_DATA_W-1:0] sext4(input logic [3:0] v);
    return {{(DEF_DATA_W-4){v[3]}}, v};
  endfunction

endpackage

// File: rtl/exu_dmem.sv
// Data memory of the execute/memory stage: DEPTH words, synchronous
// clear on reset, clocked write, combinational read gated by the load
// strobe. Addresses at or above DEPTH neither write nor read.
module exu_dmem
  import exu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic              in_range;

  assign in_range = (addr < ADDR_W'(DEPTH));

  // Reset clears every word and takes priority over a concurrent store.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (we && in_range) begin
      mem_reg[addr[AW-1:0]] <= wdata;
    end
  end

  // Read is asynchronous so a load completes within the same cycle.
  always_comb begin
    rdata = '0;
    if (re && in_range) begin
      rdata = mem_reg[addr[AW-1:0]];
    end
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory stage of the 16-bit single-cycle CPU: opcode decode to
// control strobes, ADD/AND ALU with register or immediate operand, and the
// data memory. Optional build macro EXU_ALU_FLAGS_EN adds alu_zero and
// alu_carry outputs; without it the add carry is simply dropped.
module exec_mem_unit
  import exu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [3:0]        imm4,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              dataMemRead,
  output logic              dataMemWrite,
  output logic              regWrite,
  output logic              immediate,
  output logic              ALUand,
  output logic              ALUadd,
  output logic              comparator,
  output logic              PCselect,
`ifdef EXU_ALU_FLAGS_EN
  output logic              alu_zero,
  output logic              alu_carry,
`endif
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] mem_rdata
);

  logic [DATA_W-1:0] alu_b;

  // Opcode decode; every strobe is held low while reset is asserted.
  always_comb begin
    dataMemRead  = 1'b0;
    dataMemWrite = 1'b0;
    regWrite     = 1'b0;
    immediate    = 1'b0;
    ALUand       = 1'b0;
    ALUadd       = 1'b0;
    comparator   = 1'b0;
    PCselect     = 1'b0;
    if (reset_n) begin
      case (opcode)
        OP_ADD:  begin ALUadd = 1'b1; regWrite = 1'b1; end
        OP_ADDI: begin ALUadd = 1'b1; immediate = 1'b1; regWrite = 1'b1; end
        OP_AND:  begin ALUand = 1'b1; regWrite = 1'b1; end
        OP_ANDI: begin ALUand = 1'b1; immediate = 1'b1; regWrite = 1'b1; end
        OP_LD:   begin dataMemRead = 1'b1; regWrite = 1'b1; end
        OP_ST:   dataMemWrite = 1'b1;
        OP_CMP:  comparator = 1'b1;
        OP_JMP, OP_JE, OP_JNE, OP_JA, OP_JB: PCselect = 1'b1;
        default: ;
      endcase
    end
  end

  assign alu_b = immediate ? sext4(imm4) : reg_b;

`ifdef EXU_ALU_FLAGS_EN
  logic [DATA_W:0] sum_ext;
  assign sum_ext = {1'b0, reg_a} + {1'b0, alu_b};

  // ALU result plus flags; carry only reported for an add.
  always_comb begin
    alu_out   = '0;
    alu_carry = 1'b0;
    if (ALUadd) begin
      alu_out   = sum_ext[DATA_W-1:0];
      alu_carry = sum_ext[DATA_W];
    end else if (ALUand) begin
      alu_out = reg_a & alu_b;
    end
  end

  assign alu_zero = (alu_out == '0);
`else
  // ALU result; add wraps modulo 2^DATA_W.
  always_comb begin
    alu_out = '0;
    if (ALUadd) begin
      alu_out = reg_a + alu_b;
    end else if (ALUand) begin
      alu_out = reg_a & alu_b;
    end
  end
`endif

  exu_dmem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_dmem (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (dataMemWrite),
    .re     (dataMemRead),
    .addr   (mem_addr),
    .wdata  (reg_b),
    .rdata  (mem_rdata)
  );

endmodule

// File: tb/tb_exec_mem_unit.sv
// Bench for exec_mem_unit: directed steps from the feature list followed by
// random instructions, all compared with a behavioural model (strobe table,
// integer ALU arithmetic, word array for memory).
module tb_exec_mem_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  opcode;
  logic [15:0] reg_a, reg_b;
  logic [3:0]  imm4;
  logic [11:0] mem_addr;
  logic        dataMemRead, dataMemWrite, regWrite, immediate;
  logic        ALUand, ALUadd, comparator, PCselect;
  logic [15:0] alu_out, mem_rdata;
`ifdef EXU_ALU_FLAGS_EN
  logic        alu_zero, alu_carry;
`endif
  logic [7:0]  strobes;

  int vectors = 0;
  int miscompares = 0;
  int unsigned mem_model [256];

  localparam logic [7:0] S_RD  = 8'h80;
  localparam logic [7:0] S_WR  = 8'h40;
  localparam logic [7:0] S_RW  = 8'h20;
  localparam logic [7:0] S_IM  = 8'h10;
  localparam logic [7:0] S_AND = 8'h08;
  localparam logic [7:0] S_ADD = 8'h04;
  localparam logic [7:0] S_CMP = 8'h02;
  localparam logic [7:0] S_PC  = 8'h01;

  always #5 clock = ~clock;

  assign strobes = {dataMemRead, dataMemWrite, regWrite, immediate,
                    ALUand, ALUadd, comparator, PCselect};

  exec_mem_unit dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .reg_a       (reg_a),
    .reg_b       (reg_b),
    .imm4        (imm4),
    .mem_addr    (mem_addr),
    .dataMemRead (dataMemRead),
    .dataMemWrite(dataMemWrite),
    .regWrite    (regWrite),
    .immediate   (immediate),
    .ALUand      (ALUand),
    .ALUadd      (ALUadd),
    .comparator  (comparator),
    .PCselect    (PCselect),
`ifdef EXU_ALU_FLAGS_EN
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
`endif
    .alu_out     (alu_out),
    .mem_rdata   (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_strobes(input int op, input logic rst_n);
    if (!rst_n) return 8'h00;
    case (op)
      1: return S_ADD | S_RW;
      2: return S_ADD | S_IM | S_RW;
      3: return S_AND | S_RW;
      4: return S_AND | S_IM | S_RW;
      5: return S_RD | S_RW;
      6: return S_WR;
      7: return S_CMP;
      8, 9, 10, 11, 12: return S_PC;
      default: return 8'h00;
    endcase
  endfunction

  // Compare every output against the model for the inputs currently driven.
  task automatic check_outputs();
    logic [7:0]  s;
    int unsigned a, b, sum, exp_alu, exp_rd, exp_c;
    int          simm;
    s    = model_strobes(int'(opcode), reset_n);
    a    = reg_a;
    simm = (imm4 >= 4'd8) ? int'(imm4) - 16 : int'(imm4);
    b    = ((s & S_IM) != 0) ? (int'(simm) & 32'hFFFF) : reg_b;
    sum  = a + b;
    exp_c = 0;
    if ((s & S_ADD) != 0) begin
      exp_alu = sum & 32'hFFFF;
      exp_c   = sum >> 16;
    end else if ((s & S_AND) != 0) begin
      exp_alu = a & b;
    end else begin
      exp_alu = 0;
    end
    exp_rd = (((s & S_RD) != 0) && mem_addr < 12'd256) ? mem_model[mem_addr[7:0]] : 0;
    check("strobes", 32'(strobes), 32'(s));
    check("alu_out", 32'(alu_out), exp_alu);
    check("mem_rdata", 32'(mem_rdata), exp_rd);
`ifdef EXU_ALU_FLAGS_EN
    check("alu_carry", 32'(alu_carry), exp_c);
    check("alu_zero", 32'(alu_zero), (exp_alu == 0) ? 1 : 0);
`endif
  endtask

  task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] imm, input logic [11:0] addr, input logic rst_n);
    opcode   = op;
    reg_a    = a;
    reg_b    = b;
    imm4     = imm;
    mem_addr = addr;
    reset_n  = rst_n;
    #1;
    check_outputs();
  endtask

  // Advance one clock edge and apply the same edge to the memory model.
  task automatic tick();
    @(posedge clock);
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) mem_model[i] = 0;
    end else if (((model_strobes(int'(opcode), reset_n) & S_WR) != 0) && mem_addr < 12'd256) begin
      mem_model[mem_addr[7:0]] = reg_b;
    end
    @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 0;
    opcode = 4'h0; reg_a = '0; reg_b = '0; imm4 = '0; mem_addr = '0; reset_n = 1'b0;
    @(negedge clock);

    // Reset: strobes forced low even for a valid opcode.
    apply(4'h1, 16'hFFFF, 16'h0002, 4'h0, 12'h000, 1'b0);
    check("rst_strobes", 32'(strobes), 32'h0);
    tick();

    apply(4'h5, 16'h0, 16'h0, 4'h0, 12'h010, 1'b1);
    check("ld_after_rst", 32'(mem_rdata), 32'h0);
    check("ld_strobes", 32'({dataMemRead, regWrite}), 32'h3);
    tick();

    apply(4'h1, 16'hFFFF, 16'h0002, 4'h0, 12'h000, 1'b1);
    check("add_wrap", 32'(alu_out), 32'h0001);
`ifdef EXU_ALU_FLAGS_EN
    check("add_carry", 32'(alu_carry), 32'h1);
`endif
    apply(4'h2, 16'h0005, 16'h0000, 4'hE, 12'h000, 1'b1);
    check("addi_imm", 32'(immediate), 32'h1);
    check("addi_neg", 32'(alu_out), 32'h0003);
    apply(4'h2, 16'h0005, 16'h0000, 4'h7, 12'h000, 1'b1);
    check("addi_pos", 32'(alu_out), 32'h000C);
    apply(4'h4, 16'h1234, 16'h0000, 4'hF, 12'h000, 1'b1);
    check("andi_ones", 32'(alu_out), 32'h1234);
    apply(4'h3, 16'h1234, 16'h00FF, 4'h0, 12'h000, 1'b1);
    check("and_reg", 32'(alu_out), 32'h0034);

    apply(4'h6, 16'h0, 16'hBEEF, 4'h0, 12'h020, 1'b1);
    tick();
    apply(4'h5, 16'h0, 16'h0, 4'h0, 12'h020, 1'b1);
    check("st_ld", 32'(mem_rdata), 32'hBEEF);
    apply(4'h6, 16'h0, 16'h1111, 4'h0, 12'h120, 1'b1);
    tick();
    apply(4'h5, 16'h0, 16'h0, 4'h0, 12'h120, 1'b1);
    check("ld_oob", 32'(mem_rdata), 32'h0);
    apply(4'h5, 16'h0, 16'h0, 4'h0, 12'h020, 1'b1);
    check("no_alias", 32'(mem_rdata), 32'hBEEF);

    // Reset during a store: reset wins, memory cleared.
    apply(4'h6, 16'h0, 16'hCAFE, 4'h0, 12'h030, 1'b0);
    tick();
    apply(4'h5, 16'h0, 16'h0, 4'h0, 12'h030, 1'b1);
    check("rst_store", 32'(mem_rdata), 32'h0);
    apply(4'h5, 16'h0, 16'h0, 4'h0, 12'h020, 1'b1);
    check("rst_clear", 32'(mem_rdata), 32'h0);

    apply(4'h7, 16'h1, 16'h2, 4'h0, 12'h000, 1'b1);
    check("cmp_only", 32'(strobes), 32'(S_CMP));
    for (int op = 8; op <= 15; op++) begin
      apply(4'(op), 16'h1, 16'h2, 4'h3, 12'h000, 1'b1);
      check("jmp_rsvd", 32'(strobes), (op <= 12) ? 32'(S_PC) : 32'h0);
    end

    // Random instructions against the model; addresses biased to hit stores.
    for (int n = 0; n < 400; n++) begin
      logic [11:0] addr;
      addr = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
      apply(4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom), addr,
            ($urandom_range(0, 39) != 0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
